kal_out_decimator: RTL and testbench
====================================

# kal_out_decimator

Decimating boxcar averager placed directly downstream of the gyro Kalman filter stage. It consumes the filtered state `x_out` and covariance `p_out` every clock. It discards the filter's post-reset warm-up samples, then averages 2^N consecutive states. Each window produces one decimated rate word, plus the window's peak covariance, through a single-entry valid/ready output buffer.

## Interface
- `SETTLE`, 20: clock cycles after reset whose samples are discarded; covers the filter's 19-cycle output-hold warm-up plus one register stage.
- `MAX_LOG2`, 10: largest decimation exponent; the accumulator is 32+MAX_LOG2 bits wide.
- `i_clk`  in  1  system clock; one filter sample per rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_x`  in  32  signed filtered state (Kalman `x_out`).
- `i_p`  in  32  signed covariance (Kalman `p_out`); negative values are treated as 0.
- `i_dec_log2`  in  4  decimation exponent N; window length is 2^N; values > MAX_LOG2 clamp to MAX_LOG2.
- `i_sync`  in  1  restart pulse; aborts the partial window.
- `i_ready`  in  1  consumer accepts `o_data`/`o_pmax` when high with `o_valid`.
- `i_ovf_clr`  in  1  clears the sticky `o_ovf`.
- `o_data`  out  32  signed window mean.
- `o_pmax`  out  32  maximum clamped `i_p` within the window.
- `o_valid`  out  1  output buffer holds an unconsumed result.
- `o_ovf`  out  1  sticky flag: a result was overwritten before it was consumed.

## Operation
- Two states:
  - SETTLE: counts down from SETTLE; samples are ignored. Moves to ACCUM after the cycle in which the count reaches 1.
  - ACCUM: accumulates samples.
- Window start, in ACCUM:
  - The first cycle of each window latches n = min(i_dec_log2, MAX_LOG2).
  - It loads `acc` = sign-extended `i_x`, sets `pmax` = max(`i_p`, 0) and sets `cnt` = 1.
- Subsequent window cycles: `acc` += `i_x`, `pmax` = max(`pmax`, clamped `i_p`), `cnt` += 1.
- Window end: the cycle where `cnt` == 2^n − 1, or the first cycle itself when n = 0.
  - The result `acc_final >>> n` is computed, where `acc_final` includes the current sample. The shift is arithmetic and truncates toward −inf.
  - The result is written into the output buffer with the final `pmax`.
  - The next cycle starts a new window with no gap.
- Accumulator width: 42 bits, so it cannot overflow. The shifted result always fits in 32 bits, and no saturation is needed.
- Changing `i_dec_log2` mid-window has no effect until the next window start.
- `i_sync` high in ACCUM:
  - The partial window and the current sample are discarded.
  - The next cycle is a window start.
  - The output buffer is untouched.
- `i_sync` in SETTLE is ignored.
- Output buffer:
  - A load sets `o_valid`.
  - A transfer is `o_valid && i_ready`; it clears `o_valid` unless a load occurs in the same cycle.
- Load while `o_valid && !i_ready`: the buffer is overwritten with the new result, `o_valid` stays 1, and `o_ovf` is set.
- Load and transfer in the same cycle: the old word is accepted and the new word is loaded. `o_valid` stays 1 and `o_ovf` is not set.
- `o_ovf` is cleared by `i_ovf_clr`. A set event in the same cycle as a clear wins, so `o_ovf` stays 1.
- Reset mid-operation: all state returns to reset values immediately and SETTLE restarts; no partial result is emitted.

## Timing
- Reset values:
  - `o_data` = 0, `o_pmax` = 0, `o_valid` = 0, `o_ovf` = 0.
  - State = SETTLE, settle count = SETTLE, `acc` = 0, `cnt` = 0.
- Sample presented before edge t is "sample t". The first edge after reset release is t = 1.
- Samples t = 1..SETTLE are discarded, so the first window starts with sample SETTLE+1 = 21.
- Latency: a window whose last sample is at edge t shows `o_valid` = 1 and the new `o_data`/`o_pmax` after edge t, visible in cycle t+1.
- Results are emitted one every 2^n cycles.
- `o_data`, `o_pmax`, `o_valid` and `o_ovf` are all registered; no output is combinational.
- `i_ready`, `i_sync` and `i_ovf_clr` are sampled on the rising edge only.

## Test plan
- **Settle:** `i_x` = 1000 constant, N = 2, `i_ready` = 1.
  - Required: `o_valid` never rises before the edge of sample 24.
  - Required: first `o_data` = 1000; then one `o_valid` pulse every 4 cycles.
- **Rounding and sign:** N = 1, samples −3 then −4 in one window.
  - Required: `o_data` = −4 (−7 >>> 1).
  - Samples 3, 4 must give 3.
  - N = 10 with constant −2147483648 must give −2147483648 with no wrap.
- **pmax:** N = 2, `i_p` = 50, −7, 900, 12.
  - Required: `o_pmax` = 900. A window of all-negative `i_p` must give `o_pmax` = 0.
- **Backpressure:** N = 0, `i_ready` = 0 for 3 cycles with samples 5, 6, 7.
  - Required: `o_data` = 7, `o_valid` = 1, `o_ovf` = 1.
  - Raising `i_ready` with a new sample 8 on the same edge: accepts 7, loads 8, `o_ovf` stays 1.
  - A following `i_ovf_clr` clears `o_ovf` to 0.
- **Sync and N change:** N = 3.
  - Assert `i_sync` at the 5th sample of a window. Required: the next result averages exactly the 8 samples after the sync cycle.
  - Change N to 1 mid-window. Required: the current window still takes 8 samples and the next takes 2.
- **Reset mid-window:** pull `i_rst_n` low asynchronously mid-window.
  - Required: all outputs are 0 immediately.
  - Required: the post-release first result follows the settle timing of the "Settle" scenario.

Source files
------------

// File: rtl/kal_out_decimator_if.sv
// rtl/kal_out_decimator_if.sv - sample input and decimated output bundle for kal_out_decimator
interface kal_out_decimator_if;
    logic signed [31:0] i_x;
    logic signed [31:0] i_p;
    logic [3:0]         i_dec_log2;
    logic               i_sync;
    logic               i_ready;
    logic               i_ovf_clr;
    logic signed [31:0] o_data;
    logic [31:0]        o_pmax;
    logic               o_valid;
    logic               o_ovf;

    modport slave (
        input  i_x, i_p, i_dec_log2, i_sync, i_ready, i_ovf_clr,
        output o_data, o_pmax, o_valid, o_ovf
    );

    modport master (
        output i_x, i_p, i_dec_log2, i_sync, i_ready, i_ovf_clr,
        input  o_data, o_pmax, o_valid, o_ovf
    );
endinterface

// File: rtl/kal_out_decimator.sv
// rtl/kal_out_decimator.sv - post-Kalman boxcar decimator with settle skip and single-entry output buffer
module kal_out_decimator #(
    parameter int SETTLE   = 20,
    parameter int MAX_LOG2 = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    kal_out_decimator_if.slave bus
);
    localparam int AW = 32 + MAX_LOG2;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int CW = MAX_LOG2 + 1;

    typedef enum logic {ST_SETTLE, ST_ACCUM} state_t;

    state_t                state, state_nx;
    logic [SW-1:0]         settle_cnt, settle_cnt_nx;
    logic signed [AW-1:0]  acc, acc_nx, acc_final, x_ext;
    logic [31:0]           pmax, pmax_nx, pmax_final, p_clamp;
    logic [CW-1:0]         cnt, cnt_nx, cnt_last;
    logic [3:0]            n_reg, n_reg_nx, n_now, n_use;
    logic                  win_start, win_end, load;
    logic signed [31:0]    result;
    logic signed [31:0]    data_q, data_nx;
    logic [31:0]           pmax_q, pmax_q_nx;
    logic                  valid_q, valid_nx, ovf_q, ovf_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_SETTLE;
            settle_cnt <= SW'(SETTLE);
            acc        <= '0;
            pmax       <= '0;
            cnt        <= '0;
            n_reg      <= '0;
            data_q     <= '0;
            pmax_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            acc        <= acc_nx;
            pmax       <= pmax_nx;
            cnt        <= cnt_nx;
            n_reg      <= n_reg_nx;
            data_q     <= data_nx;
            pmax_q     <= pmax_q_nx;
            valid_q    <= valid_nx;
            ovf_q      <= ovf_nx;
        end
    end

    // cnt == 0 marks a window start; the exponent is taken live there and latched for the rest
    always_comb begin
        p_clamp    = bus.i_p[31] ? 32'd0 : bus.i_p;
        n_now      = (bus.i_dec_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : bus.i_dec_log2;
        win_start  = (cnt == '0);
        n_use      = win_start ? n_now : n_reg;
        x_ext      = {{(AW-32){bus.i_x[31]}}, bus.i_x};
        acc_final  = win_start ? x_ext : acc + x_ext;
        pmax_final = (win_start || (p_clamp > pmax)) ? p_clamp : pmax;
        cnt_last   = CW'((32'd1 << n_reg) - 32'd1);
        win_end    = win_start ? (n_now == 4'd0) : (cnt == cnt_last);
        result     = 32'(acc_final >>> n_use);
    end

    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        acc_nx        = acc;
        pmax_nx       = pmax;
        cnt_nx        = cnt;
        n_reg_nx      = n_reg;
        load          = 1'b0;
        case (state)
            ST_SETTLE: begin
                settle_cnt_nx = settle_cnt - SW'(1);
                if (settle_cnt == SW'(1)) state_nx = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (bus.i_sync) begin
                    cnt_nx = '0;
                end else begin
                    acc_nx  = acc_final;
                    pmax_nx = pmax_final;
                    if (win_end) begin
                        load   = 1'b1;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                        if (win_start) n_reg_nx = n_now;
                    end
                end
            end
            default: state_nx = ST_SETTLE;
        endcase
    end

    // A load into an unconsumed buffer flags overflow; a set outranks a same-cycle clear
    always_comb begin
        data_nx   = load ? result : data_q;
        pmax_q_nx = load ? pmax_final : pmax_q;
        valid_nx  = load ? 1'b1 : ((valid_q && bus.i_ready) ? 1'b0 : valid_q);
        ovf_nx    = (load && valid_q && !bus.i_ready) ? 1'b1 : (bus.i_ovf_clr ? 1'b0 : ovf_q);
    end

    assign bus.o_data  = data_q;
    assign bus.o_pmax  = pmax_q;
    assign bus.o_valid = valid_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_kal_out_decimator.sv
// tb/tb_kal_out_decimator.sv - randomized and directed bench for kal_out_decimator with a queue-based reference
module tb_kal_out_decimator;
    localparam int SETTLE = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    kal_out_decimator_if bus();

    kal_out_decimator #(.SETTLE(SETTLE), .MAX_LOG2(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int     t_cnt;
    int     wn;
    int     wq[$];
    int     pq[$];
    logic [31:0] m_data, m_pmax;
    logic        m_valid, m_ovf;

    function automatic void model_reset();
        t_cnt = 0; wn = 0;
        wq.delete(); pq.delete();
        m_data = '0; m_pmax = '0; m_valid = 1'b0; m_ovf = 1'b0;
    endfunction

    function automatic void model_edge();
        bit     ld;
        longint s;
        int     pm, d;
        logic [31:0] nd, np;
        ld = 0; nd = '0; np = '0;
        if (t_cnt < SETTLE) begin
            t_cnt++;
        end else if (bus.i_sync) begin
            wq.delete(); pq.delete();
        end else begin
            if (wq.size() == 0) begin
                d  = int'(bus.i_dec_log2);
                wn = (d > 10) ? 10 : d;
            end
            wq.push_back(int'(bus.i_x));
            pq.push_back(int'(bus.i_p));
            if (wq.size() == (1 << wn)) begin
                s = 0; pm = 0;
                foreach (wq[i]) s += longint'(wq[i]);
                foreach (pq[i]) if (pq[i] > pm) pm = pq[i];
                nd = 32'(s >>> wn);
                np = 32'(pm);
                ld = 1;
                wq.delete(); pq.delete();
            end
        end
        if (ld && m_valid && !bus.i_ready) m_ovf = 1'b1;
        else if (bus.i_ovf_clr)            m_ovf = 1'b0;
        if (ld) begin
            m_valid = 1'b1; m_data = nd; m_pmax = np;
        end else if (m_valid && bus.i_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("valid", 32'(bus.o_valid), 32'(m_valid));
        chk("ovf",   32'(bus.o_ovf),   32'(m_ovf));
        chk("data",  bus.o_data,       m_data);
        chk("pmax",  bus.o_pmax,       m_pmax);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_ovf"},   32'(bus.o_ovf),   32'd0);
        chk({tag, "_data"},  bus.o_data,       32'd0);
        chk({tag, "_pmax"},  bus.o_pmax,       32'd0);
    endtask

    task automatic run_settle(input string tag);
        int first;
        first = 0;
        bus.i_x = 32'sd1000; bus.i_dec_log2 = 4'd2; bus.i_ready = 1'b1;
        bus.i_sync = 1'b0; bus.i_ovf_clr = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            bus.i_p = $urandom;
            step();
            if (first == 0 && bus.o_valid) first = k;
        end
        chk({tag, "_first_valid_edge"}, 32'(first), 32'd24);
        chk({tag, "_mean"}, bus.o_data, 32'd1000);
    endtask

    initial begin
        longint s;
        bus.i_x = '0; bus.i_p = '0; bus.i_dec_log2 = '0;
        bus.i_sync = 1'b0; bus.i_ready = 1'b0; bus.i_ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        run_settle("settle");

        // floor rounding on negative means, and the most negative full window
        bus.i_dec_log2 = 4'd1; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        bus.i_x = -32'sd3; step();
        bus.i_x = -32'sd4; step();
        chk("round_neg", bus.o_data, -32'sd4);
        bus.i_x = 32'sd3; step();
        bus.i_x = 32'sd4; step();
        chk("round_pos", bus.o_data, 32'sd3);
        bus.i_dec_log2 = 4'd10; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        bus.i_x = 32'h8000_0000;
        for (int i = 0; i < 1024; i++) step();
        chk("min_int_mean", bus.o_data, 32'h8000_0000);

        bus.i_dec_log2 = 4'd2; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        bus.i_x = 32'sd1;
        bus.i_p = 32'sd50;  step();
        bus.i_p = -32'sd7;  step();
        bus.i_p = 32'sd900; step();
        bus.i_p = 32'sd12;  step();
        chk("pmax_peak", bus.o_pmax, 32'd900);
        for (int i = 0; i < 4; i++) begin
            bus.i_p = 32'h8000_0000 | 32'($urandom);
            step();
        end
        chk("pmax_all_neg", bus.o_pmax, 32'd0);

        bus.i_dec_log2 = 4'd0; bus.i_ready = 1'b1; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_x = 32'sd5; step();
        bus.i_x = 32'sd6; step();
        bus.i_x = 32'sd7; step();
        chk("bp_data", bus.o_data, 32'sd7);
        chk("bp_valid", 32'(bus.o_valid), 32'd1);
        chk("bp_ovf", 32'(bus.o_ovf), 32'd1);
        bus.i_ready = 1'b1; bus.i_x = 32'sd8; step();
        chk("bp_reload_data", bus.o_data, 32'sd8);
        chk("bp_reload_ovf", 32'(bus.o_ovf), 32'd1);
        bus.i_ovf_clr = 1'b1; bus.i_x = 32'sd9; step(); bus.i_ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.o_ovf), 32'd0);

        // sync at the 5th sample, then an exponent change inside a window
        bus.i_dec_log2 = 4'd3; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin bus.i_x = $urandom; step(); end
        bus.i_sync = 1'b1; bus.i_x = $urandom; step(); bus.i_sync = 1'b0;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_x = $urandom; s += longint'(bus.i_x); step();
        end
        chk("sync_window_mean", bus.o_data, 32'(s >>> 3));
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bus.i_dec_log2 = 4'd1;
            bus.i_x = $urandom; s += longint'(bus.i_x); step();
            if (i == 6) chk("n_change_no_early", 32'(bus.o_valid), 32'd0);
        end
        chk("n_change_old_len", bus.o_data, 32'(s >>> 3));
        s = 0;
        for (int i = 0; i < 2; i++) begin
            bus.i_x = $urandom; s += longint'(bus.i_x); step();
        end
        chk("n_change_new_len", bus.o_data, 32'(s >>> 1));
        chk("n_change_new_valid", 32'(bus.o_valid), 32'd1);

        for (int i = 0; i < 400; i++) begin
            bus.i_x = $urandom; bus.i_p = $urandom;
            bus.i_dec_log2 = 4'($urandom_range(0, 15));
            bus.i_sync = ($urandom_range(0, 39) == 0);
            bus.i_ready = ($urandom_range(0, 3) != 0);
            bus.i_ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        bus.i_sync = 1'b0; bus.i_ovf_clr = 1'b0;

        // leave the buffer full with ovf set, then reset in the middle of a window
        bus.i_dec_log2 = 4'd0; bus.i_ready = 1'b0;
        bus.i_x = 32'sd77; bus.i_p = 32'sd5; step(); step();
        bus.i_dec_log2 = 4'd2; bus.i_ready = 1'b1; bus.i_sync = 1'b1; step(); bus.i_sync = 1'b0;
        step(); step();
        #3 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1 chk_zero("reset_hold");
        rst_n = 1'b1;
        run_settle("resettle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
